doc_loader: RTL

Receive-side counterpart of the document transmit path. Deserialises an 8N1 UART stream on RsRx, recognises a framed document (start byte 0xCC, 300 payload bytes, end byte 0xDD), and writes each payload byte into document memory as internal text code (ASCII minus 0x20). The block sits between the board RX pin and the document memory write port, using the same 20×15 geometry and `{y, x}` address packing as the transmit path.

---
 rtl/doc_loader.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/doc_loader.sv
// doc_loader
// Receive-side document loader. Deserialises an 8N1 UART stream, waits for a
// start-of-document byte, writes the 300 payload bytes into a 20x15 document
// memory as internal text code (ASCII - 0x20), then expects an end byte.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   RsRx        UART serial input, idle high, asynchronous to clk
//   enable      load armed; low discards all traffic and aborts a load
//   write_en    one-cycle document memory write strobe
//   write_addr  {1'b0, y[3:0], x[4:0]} of the entry being written
//   write_data  internal text code
//   busy        high from accepted start byte until completion or abort
//   done        one-cycle pulse on a valid end byte
//   error       one-cycle pulse on an aborted load
//   error_code  last abort cause (0 none, 1 framing, 2 bad terminator)
//
// Build option: define DOC_LOADER_CLAMP_EN to write 8'h00 (space) for payload
// bytes outside printable ASCII 0x20..0x7E.
//
// Loader FSM
//   state  | meaning
//   L_IDLE | clear position, wait for enable
//   L_WACK | armed, waiting for the start byte
//   L_DATA | writing payload bytes, advancing {y, x}
//   L_WEOF | payload complete, waiting for the end byte
// Receiver FSM
//   state   | meaning
//   R_IDLE  | line idle, waiting for a low level
//   R_START | half-bit delay to the middle of the start bit
//   R_DATA  | sampling 8 data bits, LSB first
//   R_STOP  | sampling the stop bit
//   R_WAIT  | after a framing error, waiting for the line to return high

module doc_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SIGACK       = 8'hCC,
    parameter logic [7:0] SIGEOF       = 8'hDD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RsRx,
    input  logic       enable,
    output logic       write_en,
    output logic [9:0] write_addr,
    output logic [7:0] write_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] error_code
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] R_IDLE  = 3'd0;
    localparam logic [2:0] R_START = 3'd1;
    localparam logic [2:0] R_DATA  = 3'd2;
    localparam logic [2:0] R_STOP  = 3'd3;
    localparam logic [2:0] R_WAIT  = 3'd4;

    localparam logic [1:0] L_IDLE = 2'd0;
    localparam logic [1:0] L_WACK = 2'd1;
    localparam logic [1:0] L_DATA = 2'd2;
    localparam logic [1:0] L_WEOF = 2'd3;

    logic          r_rx_meta;
    logic          r_rx_s;
    logic [2:0]    r_rx_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_rx_shift;
    logic          r_byte_valid;
    logic          r_frame_err;

    logic [1:0]    r_ld_state;
    logic [4:0]    r_x;
    logic [3:0]    r_y;
    logic          r_write_en;
    logic [9:0]    r_write_addr;
    logic [7:0]    r_write_data;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [1:0]    r_error_code;

    logic [7:0]    w_text;

    // Synchroniser resets to the idle-high level so that leaving reset never
    // looks like a start edge; a fresh falling edge is required.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RsRx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state   <= R_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_rx_shift   <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                R_IDLE: begin
                    if (!r_rx_s) begin
                        r_clk_cnt  <= HALF_LOAD;
                        r_rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (r_clk_cnt == '0) begin
                        if (!r_rx_s) begin
                            r_clk_cnt  <= BIT_LOAD;
                            r_bit_idx  <= '0;
                            r_rx_state <= R_DATA;
                        end else begin
                            r_rx_state <= R_IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt - CW'(1);
                    end
                end
                R_DATA: begin
                    if (r_clk_cnt == '0) begin
                        r_rx_shift <= {r_rx_s, r_rx_shift[7:1]};
                        r_clk_cnt  <= BIT_LOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= R_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt - CW'(1);
                    end
                end
                R_STOP: begin
                    if (r_clk_cnt == '0) begin
                        if (r_rx_s) begin
                            r_byte_valid <= 1'b1;
                            r_rx_state   <= R_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_rx_state  <= R_WAIT;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt - CW'(1);
                    end
                end
                R_WAIT: begin
                    if (r_rx_s) begin
                        r_rx_state <= R_IDLE;
                    end
                end
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

`ifdef DOC_LOADER_CLAMP_EN
    always_comb begin
        w_text = r_rx_shift - 8'h20;
        if (r_rx_shift < 8'h20 || r_rx_shift > 8'h7E) begin
            w_text = 8'h00;
        end
    end
`else
    always_comb begin
        w_text = r_rx_shift - 8'h20;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_state   <= L_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_error_code <= 2'd0;
        end else begin
            r_write_en <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            // Disarming takes priority over everything, including a byte
            // completing in the same cycle: that byte is dropped.
            if (!enable) begin
                r_ld_state <= L_IDLE;
                r_x        <= '0;
                r_y        <= '0;
                r_busy     <= 1'b0;
            end else begin
                case (r_ld_state)
                    L_IDLE: begin
                        r_x        <= '0;
                        r_y        <= '0;
                        r_busy     <= 1'b0;
                        r_ld_state <= L_WACK;
                    end
                    L_WACK: begin
                        if (r_byte_valid && r_rx_shift == SIGACK) begin
                            r_busy       <= 1'b1;
                            r_error_code <= 2'd0;
                            r_ld_state   <= L_DATA;
                        end
                    end
                    L_DATA: begin
                        if (r_frame_err) begin
                            r_error      <= 1'b1;
                            r_error_code <= 2'd1;
                            r_busy       <= 1'b0;
                            r_ld_state   <= L_IDLE;
                        end else if (r_byte_valid) begin
                            r_write_en   <= 1'b1;
                            r_write_addr <= {1'b0, r_y, r_x};
                            r_write_data <= w_text;
                            if (r_x == 5'd19) begin
                                r_x <= '0;
                                if (r_y == 4'd14) begin
                                    r_ld_state <= L_WEOF;
                                end else begin
                                    r_y <= r_y + 4'd1;
                                end
                            end else begin
                                r_x <= r_x + 5'd1;
                            end
                        end
                    end
                    L_WEOF: begin
                        if (r_frame_err) begin
                            r_error      <= 1'b1;
                            r_error_code <= 2'd1;
                            r_busy       <= 1'b0;
                            r_ld_state   <= L_IDLE;
                        end else if (r_byte_valid) begin
                            if (r_rx_shift == SIGEOF) begin
                                r_done <= 1'b1;
                            end else begin
                                r_error      <= 1'b1;
                                r_error_code <= 2'd2;
                            end
                            r_busy     <= 1'b0;
                            r_ld_state <= L_IDLE;
                        end
                    end
                    default: r_ld_state <= L_IDLE;
                endcase
            end
        end
    end

    assign write_en   = r_write_en;
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign error_code = r_error_code;

endmodule
